// File: rtl/systolic_array_nxn_if.sv
// Operand feed, result readout and control bundle for systolic_array_nxn.
// The slave modport is the engine's view; master is the driver's view.
interface systolic_array_nxn_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int K_W    = 8
);
  logic                  clear;
  logic                  start;
  logic [K_W-1:0]        k_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   a_col;
  logic [N*DATA_W-1:0]   b_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*ACC_W-1:0]    out_row;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    output clear, start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_last, busy, done
  );

  modport slave (
    input  clear, start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_last, busy, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic matmul C=A*B: K load beats (+1 per bubble), 2N-1 drain cycles, then N rows.
// Input stalls inject zero bubbles; readout holds each row stable until out_ready.
module systolic_array_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int K_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  systolic_array_nxn_if.slave io
);
  localparam int PW = 2 * DATA_W;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t          state_q, state_d;
  logic [K_W-1:0]  k_len_q, k_len_d;
  logic [K_W-1:0]  beat_cnt_q, beat_cnt_d, beat_cnt_nxt;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            flush;
  logic            beat_acc;
  logic            acc_en;

  logic [N-1:0][DATA_W-1:0]        a_eff, b_eff, a_row_in, b_col_in;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_in, b_in;
  logic [N-1:0][N-2:0][DATA_W-1:0] a_fwd_q, a_fwd_d;
  logic [N-2:0][N-1:0][DATA_W-1:0] b_fwd_q, b_fwd_d;
  logic [N-1:0][N-1:0][PW-1:0]     prod;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc_q, acc_d;

  assign beat_acc     = (state_q == LOAD) && io.in_valid;
  assign acc_en       = (state_q == LOAD) || (state_q == DRAIN);
  assign beat_cnt_nxt = beat_cnt_q + K_W'(1);
  assign a_eff        = beat_acc ? io.a_col : '0;
  assign b_eff        = beat_acc ? io.b_row : '0;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          k_len_d     = io.k_len;
          beat_cnt_d  = '0;
          drain_cnt_d = '0;
          flush       = 1'b1;
          state_d     = (io.k_len != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_nxt;
          if (beat_cnt_nxt == k_len_q) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Last product reaches PE(N-1,N-1) 2N-2 cycles after the final beat.
        drain_cnt_d = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DW'(2 * N - 2)) begin
          row_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (io.out_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (io.clear) begin
      state_d     = IDLE;
      k_len_d     = '0;
      beat_cnt_d  = '0;
      drain_cnt_d = '0;
      row_d       = '0;
      done_d      = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  // Row i of A and column j of B enter the array i (resp. j) cycles late.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_row_in[0] = a_eff[0];
      assign b_col_in[0] = b_eff[0];
    end else begin : g_delay
      logic [gi-1:0][DATA_W-1:0] a_sk_q, a_sk_d, b_sk_q, b_sk_d;

      always_comb begin
        a_sk_d = '0;
        b_sk_d = '0;
        if (!flush) begin
          a_sk_d[0] = a_eff[gi];
          b_sk_d[0] = b_eff[gi];
          for (int d = 1; d < gi; d++) begin
            a_sk_d[d] = a_sk_q[d-1];
            b_sk_d[d] = b_sk_q[d-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end

      assign a_row_in[gi] = a_sk_q[gi-1];
      assign b_col_in[gi] = b_sk_q[gi-1];
    end
  end

  always_comb begin
    a_in    = '0;
    b_in    = '0;
    a_fwd_d = '0;
    b_fwd_d = '0;
    prod    = '0;
    acc_d   = acc_q;
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_row_in[i];
      b_in[0][i] = b_col_in[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_fwd_q[i][j-1];
        b_in[j][i] = b_fwd_q[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = PW'($signed(a_in[i][j])) * PW'($signed(b_in[i][j]));
        if (flush) begin
          acc_d[i][j] = '0;
        end else if (acc_en) begin
          acc_d[i][j] = acc_q[i][j] + ACC_W'($signed(prod[i][j]));
        end
      end
    end
    if (!flush) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          a_fwd_d[i][j] = a_in[i][j];
          b_fwd_d[j][i] = b_in[j][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_fwd_q <= '0;
      b_fwd_q <= '0;
      acc_q   <= '0;
    end else begin
      a_fwd_q <= a_fwd_d;
      b_fwd_q <= b_fwd_d;
      acc_q   <= acc_d;
    end
  end

  assign io.in_ready  = (state_q == LOAD);
  assign io.out_valid = (state_q == OUT);
  assign io.out_last  = (state_q == OUT) && (row_q == RW'(N - 1));
  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;
  assign io.out_row   = (state_q == OUT) ? acc_q[row_q] : '0;
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn: N=4 engine (ACC_W=40) plus an ACC_W=32 copy for wrap-around.
module tb_systolic_array_nxn;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int AW   = 40;
  localparam int AW32 = 32;
  localparam int KW   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_array_nxn_if #(.N(N), .DATA_W(DW), .ACC_W(AW),   .K_W(KW)) bus ();
  systolic_array_nxn_if #(.N(N), .DATA_W(DW), .ACC_W(AW32), .K_W(KW)) bus32 ();

  systolic_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW),   .K_W(KW)) dut   (.clk(clk), .reset(reset), .io(bus));
  systolic_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW32), .K_W(KW)) dut32 (.clk(clk), .reset(reset), .io(bus32));

  int vectors = 0;
  int miscompares = 0;
  logic [N*AW-1:0] exp_q[$];
  logic [N*AW-1:0] got_rows[N];
  int a_m[N][8];
  int b_m[8][N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*AW-1:0] ref_row(input int r, input int k);
    logic [N*AW-1:0] row;
    longint s;
    logic [63:0] sv;
    row = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) s += longint'(a_m[r][kk]) * longint'(b_m[kk][j]);
      sv = s;
      row[j*AW +: AW] = sv[AW-1:0];
    end
    return row;
  endfunction

  // Starts a product at cycle t0, feeds k beats (optional bubbles before beat indices bub_a/bub_b).
  task automatic issue(input int k, input int bub_a, input int bub_b, output int t0);
    int idx;
    bit did_a, did_b, acc;
    for (int r = 0; r < N; r++) exp_q.push_back(ref_row(r, k));
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    bus.k_len = KW'(k + 5);
    idx = 0; did_a = 0; did_b = 0;
    for (int t = 0; t < 64 && idx < k; t++) begin
      if (idx == bub_a && !did_a) begin
        bus.in_valid = 1'b0; did_a = 1;
      end else if (idx == bub_b && !did_b) begin
        bus.in_valid = 1'b0; did_b = 1;
      end else begin
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          bus.a_col[i*DW +: DW] = DW'(a_m[i][idx]);
          bus.b_row[i*DW +: DW] = DW'(b_m[idx][i]);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.a_col = '0;
    bus.b_row = '0;
    vectors++;
    if (idx !== k) begin miscompares++; $display("FAIL beats_accepted: got %0d want %0d", idx, k); end
  endtask

  // Captures the readout; toggle selects out_ready pattern 1,0,0 repeating over valid cycles.
  task automatic collect(input bit toggle, output int first_cyc, output int last_cyc, output int done_cyc,
                         output int done_cnt, output bit done_busy, output int unstable,
                         output int n_rows, output int last_mask);
    logic [N*AW-1:0] prev_row;
    bit prev_stall;
    int p, after;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; done_busy = 1'b1;
    unstable = 0; n_rows = 0; last_mask = 0; prev_stall = 0; p = 0; after = 0; prev_row = '0;
    for (int r = 0; r < N; r++) got_rows[r] = 'x;
    for (int t = 0; t < 200; t++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; done_busy = bus.busy; end
      end
      if (done_cnt > 0) after++;
      if (after > 3) break;
      bus.out_ready = toggle ? (p % 3 == 0) : 1'b1;
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stall && bus.out_row !== prev_row) unstable++;
        if (bus.out_last) last_mask |= (1 << n_rows);
        if (bus.out_ready) begin
          if (n_rows < N) got_rows[n_rows] = bus.out_row;
          n_rows++;
          last_cyc = cyc;
        end
        p++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_row = bus.out_row;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.k_len = 8'd4;
    tick(); tick();
    vectors++; if (bus.in_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_row !== '0)     begin miscompares++; $display("FAIL rst_out_row: got %h want 0", bus.out_row); end
    vectors++; if (bus.out_last !== 1'b0)  begin miscompares++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0)      begin miscompares++; $display("FAIL rst_done: got %b want 0", bus.done); end
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_beats_start: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_identity();
    int t0, fc, lc, dc, dn, us, nr, lm;
    bit db;
    logic [N*AW-1:0] e;
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) begin
      a_m[i][k] = (i == k) ? 1 : 0;
      b_m[k][i] = 4 * k + i;
    end
    issue(4, -1, -1, t0);
    collect(1'b0, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (fc !== t0 + 12) begin miscompares++; $display("FAIL ident_first_valid: got %0d want %0d", fc - t0, 12); end
    vectors++; if (lc !== t0 + 15) begin miscompares++; $display("FAIL ident_last_row: got %0d want %0d", lc - t0, 15); end
    vectors++; if (dc !== t0 + 16) begin miscompares++; $display("FAIL ident_done: got %0d want %0d", dc - t0, 16); end
    vectors++; if (db !== 1'b0)    begin miscompares++; $display("FAIL ident_busy_at_done: got %b want 0", db); end
    vectors++; if (lm !== 8)       begin miscompares++; $display("FAIL ident_out_last: got %b want 1000", lm[3:0]); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL ident_row%0d: got %h want %h", r, got_rows[r], e); end
    end
  endtask

  task automatic test_bubbles();
    int t0, fc, lc, dc, dn, us, nr, lm;
    bit db;
    logic [15:0] rv;
    logic [N*AW-1:0] e;
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) begin
      rv = 16'($urandom); a_m[i][k] = int'($signed(rv));
      rv = 16'($urandom); b_m[k][i] = int'($signed(rv));
    end
    a_m[0][0] = -32768; b_m[0][0] = -32768;
    a_m[1][2] = 32767;  b_m[2][3] = 32767;
    a_m[3][1] = -32768; b_m[1][2] = 32767;
    issue(3, 1, 2, t0);
    collect(1'b0, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (fc !== t0 + 13) begin miscompares++; $display("FAIL bubble_first_valid: got %0d want %0d", fc - t0, 13); end
    vectors++; if (nr !== N)       begin miscompares++; $display("FAIL bubble_rows: got %0d want %0d", nr, N); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL bubble_row%0d: got %h want %h", r, got_rows[r], e); end
    end
  endtask

  task automatic test_stall();
    int t0, fc, lc, dc, dn, us, nr, lm;
    bit db;
    logic [N*AW-1:0] e;
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) begin
      a_m[i][k] = int'($urandom_range(0, 2000)) - 1000;
      b_m[k][i] = int'($urandom_range(0, 2000)) - 1000;
    end
    issue(4, -1, -1, t0);
    collect(1'b1, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (nr !== N)  begin miscompares++; $display("FAIL stall_rows: got %0d want %0d", nr, N); end
    vectors++; if (us !== 0)  begin miscompares++; $display("FAIL stall_stable: got %0d changes want 0", us); end
    vectors++; if (lm !== 8)  begin miscompares++; $display("FAIL stall_out_last: got %b want 1000", lm[3:0]); end
    vectors++; if (dn !== 1)  begin miscompares++; $display("FAIL stall_done_pulses: got %0d want 1", dn); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL stall_row%0d: got %h want %h", r, got_rows[r], e); end
    end
  endtask

  task automatic test_clear();
    int t0, fc, lc, dc, dn, us, nr, lm;
    bit db;
    logic [N*AW-1:0] e;
    bus.start = 1'b1; bus.k_len = 8'd4;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_col = {N{16'd7}};
    bus.b_row = {N{16'd9}};
    tick(); tick();
    bus.in_valid = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL clear_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL clear_in_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < N; i++) begin a_m[i][0] = 2; b_m[0][i] = 2; end
    issue(1, -1, -1, t0);
    collect(1'b0, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (fc !== t0 + 9) begin miscompares++; $display("FAIL clear_first_valid: got %0d want 9", fc - t0); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL clear_row%0d: got %h want %h", r, got_rows[r], e); end
    end
  endtask

  task automatic test_ignore_start();
    int t0, fc, lc, dc, dn, us, nr, lm, vc;
    bit db;
    logic [N*AW-1:0] e;
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) begin
      a_m[i][k] = i + 3 * k - 2;
      b_m[k][i] = 5 - i * k;
    end
    issue(2, -1, -1, t0);
    bus.start = 1'b1;
    bus.k_len = 8'd1;
    bus.out_ready = 1'b0;
    vc = -1;
    for (int t = 0; t < 40 && vc < 0; t++) begin
      if (bus.out_valid) vc = cyc; else tick();
    end
    tick(); tick();
    bus.start = 1'b0;
    vectors++; if (vc !== t0 + 10) begin miscompares++; $display("FAIL ignore_first_valid: got %0d want 10", vc - t0); end
    collect(1'b0, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (dn !== 1) begin miscompares++; $display("FAIL ignore_done_pulses: got %0d want 1", dn); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL ignore_row%0d: got %h want %h", r, got_rows[r], e); end
    end
    issue(0, -1, -1, t0);
    collect(1'b0, fc, lc, dc, dn, db, us, nr, lm);
    vectors++; if (fc !== t0 + 8)  begin miscompares++; $display("FAIL k0_first_valid: got %0d want 8", fc - t0); end
    vectors++; if (dc !== t0 + 12) begin miscompares++; $display("FAIL k0_done: got %0d want 12", dc - t0); end
    for (int r = 0; r < N; r++) begin
      e = exp_q.pop_front();
      vectors++; if (got_rows[r] !== e) begin miscompares++; $display("FAIL k0_row%0d: got %h want %h", r, got_rows[r], e); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, dcy, vc, nh;
    nh = 0; dcy = -1;
    bus.start = 1'b1; bus.k_len = 8'd0;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && dcy < 0; t++) begin
      if (bus.done) dcy = cyc;
      else begin
        if (bus.out_valid) begin
          nh++;
          vectors++; if (bus.out_row !== '0) begin miscompares++; $display("FAIL b2b_row: got %h want 0", bus.out_row); end
        end
        tick();
      end
    end
    vectors++; if (dcy !== t0 + 12) begin miscompares++; $display("FAIL b2b_done: got %0d want 12", dcy - t0); end
    vectors++; if (nh !== N) begin miscompares++; $display("FAIL b2b_rows: got %0d want %0d", nh, N); end
    bus.start = 1'b1; bus.k_len = 8'd0;
    t1 = cyc;
    tick();
    bus.start = 1'b0;
    vc = -1;
    for (int t = 0; t < 40 && vc < 0; t++) begin
      if (bus.out_valid) vc = cyc; else tick();
    end
    vectors++; if (vc !== t1 + 8) begin miscompares++; $display("FAIL b2b_second_valid: got %0d want 8", vc - t1); end
    for (int t = 0; t < 8; t++) tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clear_vs_handshake();
    int lc;
    bus.start = 1'b1; bus.k_len = 8'd0;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    lc = -1;
    for (int t = 0; t < 40 && lc < 0; t++) begin
      if (bus.out_last) lc = cyc; else tick();
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    vectors++; if (lc < 0)              begin miscompares++; $display("FAIL cvh_out_last: got none want one"); end
    vectors++; if (bus.done !== 1'b0)   begin miscompares++; $display("FAIL cvh_done: got %b want 0", bus.done); end
    vectors++; if (bus.busy !== 1'b0)   begin miscompares++; $display("FAIL cvh_busy: got %b want 0", bus.busy); end
    tick();
    vectors++; if (bus.done !== 1'b0)   begin miscompares++; $display("FAIL cvh_done_late: got %b want 0", bus.done); end
  endtask

  task automatic test_wrap();
    int t0, idx, vc;
    bit acc;
    bus32.start = 1'b1; bus32.k_len = 8'd255;
    t0 = cyc;
    tick();
    bus32.start = 1'b0;
    bus32.a_col = {N{16'h8000}};
    bus32.b_row = {N{16'h8000}};
    idx = 0;
    for (int t = 0; t < 400 && idx < 255; t++) begin
      bus32.in_valid = 1'b1;
      acc = bus32.in_ready;
      tick();
      if (acc) idx++;
    end
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    vc = -1;
    for (int t = 0; t < 50 && vc < 0; t++) begin
      if (bus32.out_valid) vc = cyc; else tick();
    end
    vectors++; if (vc !== t0 + 263) begin miscompares++; $display("FAIL wrap_first_valid: got %0d want 263", vc - t0); end
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (bus32.out_row[j*AW32 +: AW32] !== 32'hC000_0000) begin
          miscompares++; $display("FAIL wrap_c%0d%0d: got %h want c0000000", r, j, bus32.out_row[j*AW32 +: AW32]);
        end
      end
      vectors++; if (bus32.out_last !== (r == N - 1)) begin miscompares++; $display("FAIL wrap_last%0d: got %b", r, bus32.out_last); end
      tick();
    end
    bus32.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    bus.clear = 0; bus.start = 0; bus.k_len = '0; bus.in_valid = 0;
    bus.a_col = '0; bus.b_row = '0; bus.out_ready = 0;
    bus32.clear = 0; bus32.start = 0; bus32.k_len = '0; bus32.in_valid = 0;
    bus32.a_col = '0; bus32.b_row = '0; bus32.out_ready = 0;
    test_reset();
    test_identity();
    test_bubbles();
    test_stall();
    test_clear();
    test_ignore_start();
    test_back_to_back();
    test_clear_vs_handshake();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
